// File: rtl/seg_scan_driver.sv
// Two-digit common-anode 7-segment scan driver.
// Digits are shadowed once per frame so a display never mixes old and new
// values; the tens digit can blank on zero and the whole display blinks
// while the (shadowed) finish flag is set. Every output is registered: the
// next-state values are computed first and the outputs are decoded from
// them, so the outputs line up with the counters they describe.
module seg_scan_driver #(
  parameter int SCAN_MAX  = 11_999,
  parameter int BLINK_MAX = 5_999_999,
  parameter bit LZ_BLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       finish,
  input  logic [3:0] seg1_value,
  input  logic [3:0] seg2_value,
  output logic [7:0] seg_out,
  output logic [1:0] dig_sel,
  output logic       frame_tick
);

  localparam logic [13:0] SCAN_LAST  = 14'(SCAN_MAX);
  localparam logic [22:0] BLINK_LAST = 23'(BLINK_MAX);

  logic [13:0] scan_cnt, n_cnt;
  logic        slot, n_slot;          // 0 = ones, 1 = tens
  logic [22:0] blink_cnt, n_bcnt;
  logic        blink_ph, n_bph;       // 1 = dark half-period
  logic [3:0]  sh1, sh2, n_sh1, n_sh2;
  logic        sh_fin, n_fin;
  logic [7:0]  n_seg;
  logic [1:0]  n_dig;
  logic        n_tick;
  logic [3:0]  digit;

  // BCD to active-low segments {dp,g,f,e,d,c,b,a}; non-BCD shows a dash
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 8'hC0;
      4'd1: decode = 8'hF9;
      4'd2: decode = 8'hA4;
      4'd3: decode = 8'hB0;
      4'd4: decode = 8'h99;
      4'd5: decode = 8'h92;
      4'd6: decode = 8'h82;
      4'd7: decode = 8'hF8;
      4'd8: decode = 8'h80;
      4'd9: decode = 8'h90;
      default: decode = 8'hBF;
    endcase
  endfunction

  // Next-state: scan/slot sequencing, frame capture, blink timing
  always_comb begin
    n_cnt  = scan_cnt;
    n_slot = slot;
    n_bcnt = blink_cnt;
    n_bph  = blink_ph;
    n_sh1  = sh1;
    n_sh2  = sh2;
    n_fin  = sh_fin;
    n_tick = 1'b0;
    if (!enable) begin
      // Disabled: everything parked, shadows track inputs so re-enable is fresh
      n_cnt  = '0;
      n_slot = 1'b0;
      n_bcnt = '0;
      n_bph  = 1'b0;
      n_sh1  = seg1_value;
      n_sh2  = seg2_value;
      n_fin  = finish;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        n_cnt  = '0;
        n_slot = ~slot;
        if (slot) begin
          // tens -> ones wrap starts a new frame
          n_sh1  = seg1_value;
          n_sh2  = seg2_value;
          n_fin  = finish;
          n_tick = 1'b1;
        end
      end else begin
        n_cnt = scan_cnt + 14'd1;
      end
      // A fresh finish starts on the visible phase; no finish holds blink idle
      if (!n_fin || !sh_fin) begin
        n_bcnt = '0;
        n_bph  = 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        n_bcnt = '0;
        n_bph  = ~blink_ph;
      end else begin
        n_bcnt = blink_cnt + 23'd1;
      end
    end
  end

  // Output decode from next-state so outputs are registered and aligned
  always_comb begin
    digit = n_slot ? n_sh2 : n_sh1;
    n_seg = 8'hFF;
    n_dig = 2'b11;
    if (enable && n_cnt != '0) begin
      n_dig = n_slot ? 2'b01 : 2'b10;
      if (!n_bph && !(LZ_BLANK && n_slot && n_sh2 == 4'd0))
        n_seg = decode(digit);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt   <= '0;
      slot       <= 1'b0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      sh1        <= '0;
      sh2        <= '0;
      sh_fin     <= 1'b0;
      seg_out    <= 8'hFF;
      dig_sel    <= 2'b11;
      frame_tick <= 1'b0;
    end else begin
      scan_cnt   <= n_cnt;
      slot       <= n_slot;
      blink_cnt  <= n_bcnt;
      blink_ph   <= n_bph;
      sh1        <= n_sh1;
      sh2        <= n_sh2;
      sh_fin     <= n_fin;
      seg_out    <= n_seg;
      dig_sel    <= n_dig;
      frame_tick <= n_tick;
    end
  end

endmodule
